// File: rtl/ascii_number_stream_ctrl_if.sv
// Byte-stream input and parsed-number output handshakes of the ASCII number parser.
interface ascii_number_stream_ctrl_if #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 8
);
  logic [7:0]             in_byte;
  logic                   in_valid;
  logic                   in_ready;
  logic [VALUE_WIDTH-1:0] out_value;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_valid;
  logic                   out_ready;

  // master: the parser itself; slave: the byte source plus the downstream consumer
  modport master (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_value, out_index, out_valid
  );

  modport slave (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_value, out_index, out_valid
  );
endinterface

// File: rtl/ascii_number_stream_ctrl.sv
// Parses an ASCII decimal byte stream into one binary number per line and hands
// each number, tagged with the index of its terminating byte, to the next stage.
module ascii_number_stream_ctrl #(
  parameter int VALUE_WIDTH = 32,
  parameter int INDEX_WIDTH = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ascii_number_stream_ctrl_if.master bus,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   done,
  output logic                   err_char,
  output logic                   err_ovf
);
  localparam int WIDE = VALUE_WIDTH + 4;

  typedef enum logic [1:0] {ACCUM, EMIT, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [VALUE_WIDTH-1:0] acc;
  logic                   digits;
  logic                   eos_pending;
  logic [INDEX_WIDTH-1:0] index;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   err_char_q;
  logic                   err_ovf_q;

  logic                   in_ready_c;
  logic                   out_valid_c;
  logic                   done_c;
  logic                   accept;
  logic                   is_digit;
  logic                   is_nl;
  logic                   is_eos;
  logic [WIDE-1:0]        acc_wide;
  logic                   acc_ovf;

  assign accept   = bus.in_valid && in_ready_c;
  assign is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
  assign is_nl    = (bus.in_byte == 8'h0A);
  assign is_eos   = (bus.in_byte == 8'h00);

  // For '0'..'9' the low nibble of the ASCII code is the digit value itself
  assign acc_wide = (WIDE'(acc) * WIDE'(10)) + WIDE'(bus.in_byte[3:0]);
  assign acc_ovf  = |acc_wide[WIDE-1:VALUE_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (accept) begin
          if (is_nl && digits) begin
            state_next = EMIT;
          end else if (is_eos) begin
            state_next = digits ? EMIT : DONE;
          end
        end
      end
      EMIT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = eos_pending ? DONE : ACCUM;
        end
      end
      DONE: begin
        done_c = 1'b1;
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      digits      <= 1'b0;
      eos_pending <= 1'b0;
      index       <= '0;
      value_q     <= '0;
      index_q     <= '0;
      count_q     <= '0;
      err_char_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        index <= index + INDEX_WIDTH'(1);
        if (is_digit) begin
          acc    <= acc_wide[VALUE_WIDTH-1:0];
          digits <= 1'b1;
          if (acc_ovf) begin
            err_ovf_q <= 1'b1;
          end
        end else if (is_nl || is_eos) begin
          // Empty lines fall through here with nothing latched
          if (digits) begin
            value_q     <= acc;
            index_q     <= index;
            acc         <= '0;
            digits      <= 1'b0;
            eos_pending <= is_eos;
          end
        end else begin
          err_char_q <= 1'b1;
        end
      end
      if (out_valid_c && bus.out_ready) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_value = value_q;
  assign bus.out_index = index_q;
  assign count         = count_q;
  assign done          = done_c;
  assign err_char      = err_char_q;
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_ascii_number_stream_ctrl.sv
// Scoreboarded bench for the ASCII number parser: a 32-bit instance for the main
// scenarios and an 8-bit instance for accumulator overflow.
module tb_ascii_number_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] count, count8;
  logic        done, done8, err_char, err_char8, err_ovf, err_ovf8;

  ascii_number_stream_ctrl_if #(.VALUE_WIDTH(32), .INDEX_WIDTH(8)) bus ();
  ascii_number_stream_ctrl_if #(.VALUE_WIDTH(8),  .INDEX_WIDTH(8)) bus8 ();

  ascii_number_stream_ctrl #(.VALUE_WIDTH(32), .INDEX_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count), .done(done),
    .err_char(err_char), .err_ovf(err_ovf)
  );

  ascii_number_stream_ctrl #(.VALUE_WIDTH(8), .INDEX_WIDTH(8), .COUNT_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .count(count8), .done(done8),
    .err_char(err_char8), .err_ovf(err_ovf8)
  );

  typedef struct {
    logic [31:0] value;
    logic [7:0]  index;
    logic        bad;
  } rec_t;

  typedef struct {
    string       text;
    logic [31:0] value;
    logic        ovf;
  } vec_t;

  rec_t exp_q[$], exp8_q[$], obs_q[$], obs8_q[$];
  int   errors = 0;
  int   checks = 0;

  // Output monitors: record each handshaken number, flagging any change while
  // stalled or in_ready seen high while out_valid is up.
  logic        held = 1'b0, held8 = 1'b0, bad = 1'b0, bad8 = 1'b0;
  logic [31:0] hv, hv8;
  logic [7:0]  hi, hi8;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (bus.in_ready) bad = 1'b1;
      if (held && (bus.out_value !== hv || bus.out_index !== hi)) bad = 1'b1;
      if (bus.out_ready) begin
        obs_q.push_back('{bus.out_value, bus.out_index, bad});
        held = 1'b0;
        bad  = 1'b0;
      end else begin
        held = 1'b1;
        hv   = bus.out_value;
        hi   = bus.out_index;
      end
    end else begin
      held = 1'b0;
      bad  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus8.out_valid) begin
      if (bus8.in_ready) bad8 = 1'b1;
      if (held8 && (32'(bus8.out_value) !== hv8 || bus8.out_index !== hi8)) bad8 = 1'b1;
      if (bus8.out_ready) begin
        obs8_q.push_back('{32'(bus8.out_value), bus8.out_index, bad8});
        held8 = 1'b0;
        bad8  = 1'b0;
      end else begin
        held8 = 1'b1;
        hv8   = 32'(bus8.out_value);
        hi8   = bus8.out_index;
      end
    end else begin
      held8 = 1'b0;
      bad8  = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit sel, input logic [31:0] v, input logic [7:0] i);
    if (sel) exp8_q.push_back('{v, i, 1'b0});
    else     exp_q.push_back('{v, i, 1'b0});
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus8.in_valid = 1'b0;
    bus.in_byte   = 8'h00;
    bus8.in_byte  = 8'h00;
    bus.out_ready = 1'b1;
    bus8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); exp8_q.delete(); obs_q.delete(); obs8_q.delete();
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int unsigned n = 0;
    if (sel) begin bus8.in_byte = b; bus8.in_valid = 1'b1; end
    else     begin bus.in_byte  = b; bus.in_valid  = 1'b1; end
    forever begin
      @(negedge clk);
      if (sel ? bus8.in_ready : bus.in_ready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d never accepted, required accept within 100 cycles", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (sel) bus8.in_valid = 1'b0;
    else     bus.in_valid  = 1'b0;
  endtask

  task automatic send_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  // Pops observed numbers against the expected queue until it empties
  task automatic drain(input bit sel, input string tag);
    rec_t e, o;
    int unsigned n = 0;
    while ((sel ? exp8_q.size() : exp_q.size()) != 0 && n < 200) begin
      if ((sel ? obs8_q.size() : obs_q.size()) != 0) begin
        if (sel) begin e = exp8_q.pop_front(); o = obs8_q.pop_front(); end
        else     begin e = exp_q.pop_front();  o = obs_q.pop_front();  end
        check({tag, "_value"}, o.value, e.value);
        check({tag, "_index"}, o.index, e.index);
        check({tag, "_stable"}, o.bad, 1'b0);
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check({tag, "_pending"}, sel ? exp8_q.size() : exp_q.size(), 0);
    check({tag, "_extra"}, sel ? obs8_q.size() : obs_q.size(), 0);
  endtask

  vec_t tbl[4];

  initial begin
    int unsigned idx;

    tbl[0] = '{"0\n",          32'd0,          1'b0};
    tbl[1] = '{"007\n",        32'd7,          1'b0};
    tbl[2] = '{"4294967295\n", 32'hFFFF_FFFF,  1'b0};
    tbl[3] = '{"4294967296\n", 32'd0,          1'b1};

    do_reset();
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_value", bus.out_value, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_err_char", err_char, 0);
    check("rst_err_ovf", err_ovf, 0);

    // Two lines then EOS on an empty line
    push_exp(0, 32'd12, 8'd2);
    push_exp(0, 32'd1969, 8'd7);
    send_str(0, "12\n1969\n");
    send_byte(0, 8'h00);
    check("eos_done", done, 1);
    check("eos_in_ready", bus.in_ready, 0);
    drain(0, "two_lines");
    check("two_lines_count", count, 2);
    check("two_lines_err_char", err_char, 0);
    check("two_lines_err_ovf", err_ovf, 0);

    // Downstream stall for 5 cycles
    do_reset();
    bus.out_ready = 1'b0;
    push_exp(0, 32'd100756, 8'd6);
    send_str(0, "100756\n");
    check("stall_latency_valid", bus.out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_value", bus.out_value, 32'd100756);
    end
    bus.out_ready = 1'b1;
    drain(0, "stall");
    check("stall_count", count, 1);
    check("stall_in_ready_after", bus.in_ready, 1);

    // Empty lines, then a number closed by EOS
    do_reset();
    push_exp(0, 32'd14, 8'd4);
    send_str(0, "\n\n14");
    send_byte(0, 8'h00);
    check("eos_emit_valid", bus.out_valid, 1);
    drain(0, "eos_num");
    check("eos_num_done", done, 1);
    check("eos_num_count", count, 1);

    // Illegal character is discarded and flagged stickily
    do_reset();
    push_exp(0, 32'd14, 8'd3);
    send_str(0, "1x4\n");
    drain(0, "bad_char");
    check("bad_char_flag", err_char, 1);
    push_exp(0, 32'd5, 8'd5);
    send_str(0, "5\n");
    drain(0, "after_bad");
    check("bad_char_sticky", err_char, 1);
    check("bad_char_count", count, 2);

    // Narrow accumulator overflow
    do_reset();
    push_exp(1, 32'd44, 8'd3);
    send_str(1, "300\n");
    drain(1, "ovf8");
    check("ovf8_flag", err_ovf8, 1);
    push_exp(1, 32'd7, 8'd5);
    send_str(1, "7\n");
    drain(1, "ovf8_next");
    check("ovf8_sticky", err_ovf8, 1);
    check("ovf8_count", count8, 2);

    // Table of boundary values on the full-width accumulator
    do_reset();
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      push_exp(0, tbl[i].value, 8'(idx + tbl[i].text.len() - 1));
      idx += tbl[i].text.len();
      send_str(0, tbl[i].text);
      drain(0, "table");
      check("table_err_ovf", err_ovf, tbl[i].ovf);
      check("table_count", count, i + 1);
    end

    // Reset mid-number with a byte offered during the reset cycle
    do_reset();
    send_str(0, "123");
    bus.in_byte  = 8'h39;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_value", bus.out_value, 0);
    check("midrst_done", done, 0);
    push_exp(0, 32'd5, 8'd1);
    send_str(0, "5\n");
    drain(0, "midrst");
    check("midrst_count_after", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ascii_number_stream_ctrl.md
Name: ascii_number_stream_ctrl

Overview:
- Sequences the numbers-input converter.
- Consumes an ASCII byte stream, one puzzle-input byte per handshake.
- Accumulates decimal digits into a binary value and detects line terminators.
- Emits one parsed number per line, tagged with the stream index of its terminating newline, to the downstream compute stage (fuel calculator).

Parameters:
- VALUE_WIDTH, 32, width of accumulated/emitted number.
- INDEX_WIDTH, 8, width of byte-index counter (wraps).
- COUNT_WIDTH, 16, width of emitted-number counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_byte  input  8  ASCII byte from input stream.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  block accepts in_byte this cycle.
- out_value  output  VALUE_WIDTH  parsed number.
- out_index  output  INDEX_WIDTH  index of the byte that terminated the number.
- out_valid  output  1  out_value/out_index valid.
- out_ready  input  1  downstream accepts output.
- count  output  COUNT_WIDTH  numbers emitted since reset.
- done  output  1  end of stream reached and final number consumed.
- err_char  output  1  sticky: non-digit, non-terminator byte seen.
- err_ovf  output  1  sticky: accumulator overflowed.

Behaviour:
- Clock/reset: one clock, clk; synchronous active-high reset, rst. Reset wins over all other events in the same cycle, including mid-emit.
- Reset values: state=ACCUM, acc=0, digits=0, index=0, out_valid=0, out_value=0, out_index=0, count=0, done=0, err_char=0, err_ovf=0.
- Byte accept: in_valid && in_ready. Every accepted byte increments index modulo 2^INDEX_WIDTH after use. The first byte has index 0.
- Byte classes:
  - digit: 0x30..0x39.
  - newline: 0x0A (0xDA after subtracting '0').
  - EOS: 0x00.
  - other: any remaining value.
- States:
  - ACCUM: in_ready=1, out_valid=0.
    - digit: acc <= acc*10 + (byte-0x30), truncated to VALUE_WIDTH; digits <= 1. If the true result exceeds 2^VALUE_WIDTH-1, set err_ovf.
    - newline with digits=1: latch out_value=acc and out_index=current index; clear acc and digits; go to EMIT.
    - newline with digits=0 (empty line): no emit; stay in ACCUM.
    - EOS with digits=1: latch as for newline, with out_index = index of the EOS byte; set eos_pending; go to EMIT.
    - EOS with digits=0: go to DONE.
    - other: set err_char; byte discarded; acc is unchanged.
  - EMIT: in_ready=0, out_valid=1. out_value and out_index are held stable until out_ready.
    - On out_valid && out_ready: count++ (wraps).
    - Next state is DONE if eos_pending, else ACCUM.
  - DONE: in_ready=0, out_valid=0, done=1. Left only by rst.
- Latency:
  - Terminator accepted in cycle N: out_valid=1 in cycle N+1.
  - Output handshake in cycle M: in_ready=1 (or done=1) in cycle M+1.
  - Throughput: 1 byte/cycle in ACCUM; 1 bubble per emitted number minimum.
- Error flags: err_char and err_ovf are sticky and clear only on rst. They do not stall the stream.
- Signal stability: in_valid may toggle freely; in_byte is sampled only on accept.

Test Plan:
- "12\n1969\n\0", out_ready=1: emits 12 (idx 2) and 1969 (idx 7); done=1 one cycle after the EOS accept; count=2; no errors.
- "100756\n" with out_ready=0 for 5 cycles after out_valid rises: out_value=100756 and out_index=6 held stable, in_ready=0 throughout; after the handshake, count=1 and in_ready=1 on the next cycle.
- "\n\n14\0": empty lines produce no output; emits 14 with idx 4 (the EOS byte); then done=1, count=1.
- "1x4\n": err_char=1, emits 14 idx 3; err_char stays 1 after further valid lines.
- VALUE_WIDTH=8, "300\n": emits 44 (300 mod 256), err_ovf=1. Then "7\n": emits 7, err_ovf still 1.
- "123" then rst asserted while in_valid=1, then "5\n": all outputs return to reset values; emits 5 with idx 1; rst-cycle byte not accepted.
